// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the MEM-stage data-memory unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: dmem_state_t FSM encoding, load/store funct3 encodings.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for data-memory accesses: store byte enables/shift, load extraction/extension, alignment check.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports: funct3_i (size/sign), addr_lo_i (byte offset), wdata_i (raw store data),
//        rdata_i (raw cache word), mbe_o, wdata_o (lane-shifted), rdata_o (extended), misaligned_o.
module dmem_align
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic [2:0]       funct3_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [width-1:0] wdata_i,
    input  logic [width-1:0] rdata_i,
    output logic [3:0]       mbe_o,
    output logic [width-1:0] wdata_o,
    output logic [width-1:0] rdata_o,
    output logic             misaligned_o
);

    // Byte offset expressed as a bit shift amount.
    logic [4:0]       sh_amt;
    logic [width-1:0] rshift;

    assign sh_amt = {addr_lo_i, 3'b000};
    assign rshift = rdata_i >> sh_amt;

    always_comb begin
        mbe_o   = 4'b0000;
        wdata_o = wdata_i << sh_amt;
        case (funct3_i)
            sb:      mbe_o = 4'b0001 << addr_lo_i;
            sh:      mbe_o = 4'b0011 << addr_lo_i;
            sw: begin
                mbe_o   = 4'b1111;
                wdata_o = wdata_i;
            end
            default: mbe_o = 4'b0000;
        endcase
    end

    always_comb begin
        rdata_o = '0;
        case (funct3_i)
            lb:      rdata_o = {{(width-8){rshift[7]}}, rshift[7:0]};
            lh:      rdata_o = {{(width-16){rshift[15]}}, rshift[15:0]};
            lw:      rdata_o = rshift;
            lbu:     rdata_o = {{(width-8){1'b0}}, rshift[7:0]};
            lhu:     rdata_o = {{(width-16){1'b0}}, rshift[15:0]};
            default: rdata_o = '0;
        endcase
    end

    // Halfword codes share 001 between LH and SH, word codes share 010
    // between LW and SW, so one check covers both directions.
    always_comb begin
        misaligned_o = 1'b0;
        case (funct3_i)
            lh, lhu: misaligned_o = addr_lo_i[0];
            lw:      misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// MEM-stage data-memory unit: issues one cache request per load/store, stalls the pipeline until the response, extends load data.
// Latency: memory op occupies 1 IDLE + k ACCESS + 1 DONE cycle (min 3); non-memory ops pass with zero stall.
// Backpressure: stall_o held high from request acceptance until the cache response; MEM/WB loads whenever stall_o is low.
//
// Ports: clk/rst (sync, active-low); EX/MEM side mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i;
//        cache side dmem_read_o, dmem_write_o, dmem_address_o, dmem_wdata_o, dmem_mbe_o, dmem_rdata_i, dmem_resp_i;
//        pipeline side stall_o, mem_wb_load_o, rdata_o, misaligned_o.
module dmem_unit
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [2:0]       funct3_i,
    input  logic [width-1:0] addr_i,
    input  logic [width-1:0] wdata_i,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic [width-1:0] dmem_address_o,
    output logic [width-1:0] dmem_wdata_o,
    output logic [3:0]       dmem_mbe_o,
    input  logic [width-1:0] dmem_rdata_i,
    input  logic             dmem_resp_i,
    output logic             stall_o,
    output logic             mem_wb_load_o,
    output logic [width-1:0] rdata_o,
    output logic             misaligned_o
);

    dmem_state_t      state_q, state_d;

    logic             read_q, write_q;
    logic [width-1:0] addr_q;
    logic [width-1:0] wdata_q;
    logic [3:0]       mbe_q;
    logic [2:0]       funct3_q;
    logic [width-1:0] rdata_q;

    logic             in_idle, in_access;
    logic             req, issue;
    logic [2:0]       al_funct3;
    logic [1:0]       al_addr_lo;
    logic [3:0]       al_mbe;
    logic [width-1:0] al_wdata, al_rdata;
    logic             al_mis;

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign req       = mem_read_i | mem_write_i;

    // A single lane steerer serves both phases: in IDLE it looks at the live
    // EX/MEM request (alignment check, store lanes to latch), afterwards it
    // looks at the latched request to extract the returned load data.
    assign al_funct3  = in_idle ? funct3_i     : funct3_q;
    assign al_addr_lo = in_idle ? addr_i[1:0]  : addr_q[1:0];

    dmem_align #(.width(width)) u_align (
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .wdata_i      (wdata_i),
        .rdata_i      (dmem_rdata_i),
        .mbe_o        (al_mbe),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis)
    );

    assign issue = in_idle & req & ~al_mis;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue)       state_d = ACCESS;
            ACCESS:  if (dmem_resp_i) state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Request latch: captured once on acceptance so the cache sees a stable
    // request even though EX/MEM is frozen rather than re-read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mbe_q    <= 4'b0000;
            funct3_q <= 3'b000;
        end else if (issue) begin
            read_q   <= mem_read_i;
            write_q  <= mem_write_i & ~mem_read_i;
            addr_q   <= addr_i;
            wdata_q  <= al_wdata;
            mbe_q    <= mem_read_i ? 4'b0000 : al_mbe;
            funct3_q <= funct3_i;
        end else if (in_access && dmem_resp_i) begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end
    end

    // Load result register; stores and non-memory cycles leave it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (in_access && dmem_resp_i && read_q) begin
            rdata_q <= al_rdata;
        end else if (in_idle && mem_read_i && al_mis) begin
            rdata_q <= '0;
        end
    end

    assign dmem_read_o    = read_q & in_access;
    assign dmem_write_o   = write_q & in_access;
    assign dmem_address_o = {addr_q[width-1:2], 2'b00};
    assign dmem_wdata_o   = wdata_q;
    assign dmem_mbe_o     = mbe_q;

    assign stall_o       = issue | in_access;
    assign mem_wb_load_o = ~stall_o;
    assign rdata_o       = rdata_q;
    assign misaligned_o  = in_idle & req & al_mis;

endmodule

// File: tb/tb_dmem_unit.sv
module tb_dmem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_read_o, dmem_write_o;
    logic [31:0] dmem_address_o, dmem_wdata_o;
    logic [3:0]  dmem_mbe_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_resp_i;
    logic        stall_o, mem_wb_load_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_unit #(.width(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .funct3_i       (funct3_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .dmem_read_o    (dmem_read_o),
        .dmem_write_o   (dmem_write_o),
        .dmem_address_o (dmem_address_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_mbe_o     (dmem_mbe_o),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_resp_i    (dmem_resp_i),
        .stall_o        (stall_o),
        .mem_wb_load_o  (mem_wb_load_o),
        .rdata_o        (rdata_o),
        .misaligned_o   (misaligned_o)
    );

    // Drives one memory op from IDLE through DONE with a cache that answers in
    // the lat-th ACCESS cycle. Returns what was observed; callers compare.
    // Entered and left at posedge+2.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int lat,
                         output int cyc, output int stalls, output int rds, output int wrs,
                         output logic [31:0] rdo, output logic [3:0] mbe_s,
                         output logic [31:0] addr_s, output logic [31:0] wdat_s,
                         output logic held, output logic done, output logic ldo,
                         output logic mis_seen);
        int k;
        k = 0; cyc = 0; stalls = 0; rds = 0; wrs = 0;
        rdo = '0; mbe_s = '0; addr_s = '0; wdat_s = '0;
        held = 1'b1; done = 1'b0; ldo = 1'b0; mis_seen = 1'b0;
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (misaligned_o) mis_seen = 1'b1;
            if (stall_o) stalls++;
            if (dmem_read_o) rds++;
            if (dmem_write_o) wrs++;
            if (dmem_read_o || dmem_write_o) begin
                k++;
                if (k == 1) begin
                    mbe_s = dmem_mbe_o; addr_s = dmem_address_o; wdat_s = dmem_wdata_o;
                end else if (mbe_s !== dmem_mbe_o || addr_s !== dmem_address_o || wdat_s !== dmem_wdata_o) begin
                    held = 1'b0;
                end
                dmem_resp_i  = (k == lat);
                dmem_rdata_i = (k == lat) ? rdat : 32'h5A5A_5A5A;
            end else if (k > 0 && !stall_o) begin
                done = 1'b1; rdo = rdata_o; ldo = mem_wb_load_o;
            end
            cyc = c + 1;
            @(posedge clk); #2;
            dmem_resp_i = 1'b0;
        end
        mem_read_i = 1'b0; mem_write_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_read_i = 0; mem_write_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
        dmem_rdata_i = 0; dmem_resp_i = 0;
        @(posedge clk); #2; #1;
        checks++;
        if ({dmem_read_o, dmem_write_o, misaligned_o, stall_o, mem_wb_load_o} !== 5'b00001) begin
            errors++; $display("FAIL reset_ctrl got %b want 00001",
                {dmem_read_o, dmem_write_o, misaligned_o, stall_o, mem_wb_load_o});
        end
        checks++;
        if (dmem_address_o !== 32'h0 || dmem_wdata_o !== 32'h0 || dmem_mbe_o !== 4'h0) begin
            errors++; $display("FAIL reset_bus got addr %h wdata %h mbe %b want 0", dmem_address_o, dmem_wdata_o, dmem_mbe_o);
        end
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", rdata_o);
        end
        rst = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_nonmem();
        logic bad;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            dmem_resp_i = (c == 1);
            dmem_rdata_i = 32'hFFFF_FFFF;
            #1;
            if (stall_o !== 1'b0 || mem_wb_load_o !== 1'b1 || dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0) bad = 1'b1;
            @(posedge clk); #2;
        end
        dmem_resp_i = 1'b0;
        #1;
        checks++;
        if (bad) begin
            errors++; $display("FAIL nonmem_stall got stall/req activity want none");
        end
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++; $display("FAIL nonmem_stray_resp got rdata %h want 0", rdata_o);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_lw();
        int cyc, st, rds, wrs;
        logic [31:0] rdo, as, ws, e;
        logic [3:0] ms;
        logic held, done, ldo, mis;
        exp_q.push_back(32'hDEAD_BEEF);
        do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2,
              cyc, st, rds, wrs, rdo, ms, as, ws, held, done, ldo, mis);
        checks++;
        if (!done) begin errors++; $display("FAIL lw_done got timeout want DONE"); end
        checks++;
        if (rds !== 2 || wrs !== 0) begin errors++; $display("FAIL lw_reqs got rd %0d wr %0d want 2 0", rds, wrs); end
        checks++;
        if (st !== 3 || cyc !== 4) begin errors++; $display("FAIL lw_stall got stall %0d cyc %0d want 3 4", st, cyc); end
        checks++;
        if (as !== 32'h100 || ldo !== 1'b1 || mis !== 1'b0) begin
            errors++; $display("FAIL lw_addr_load got addr %h ld %b mis %b want 100 1 0", as, ldo, mis);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdo !== e) begin errors++; $display("FAIL lw_rdata got %h want %h", rdo, e); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3[4]   = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] ad[4]   = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] res[4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8011, 32'hFFFF_8011};
        int cyc, st, rds, wrs;
        logic [31:0] rdo, as, ws, e;
        logic [3:0] ms;
        logic held, done, ldo, mis;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(res[i]);
            do_op(1, 0, f3[i], ad[i], 32'h0, 32'h8011_2233, 1,
                  cyc, st, rds, wrs, rdo, ms, as, ws, held, done, ldo, mis);
            checks++;
            e = exp_q.pop_front();
            if (!done || rdo !== e || cyc !== 3) begin
                errors++; $display("FAIL load_ext_%0d got %h cyc %0d done %b want %h cyc 3", i, rdo, cyc, done, e);
            end
        end
    endtask

    task automatic test_store();
        int cyc, st, rds, wrs;
        logic [31:0] rdo, as, ws, e;
        logic [3:0] ms;
        logic held, done, ldo, mis;
        exp_q.push_back(32'hFFFF_8011);
        do_op(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3,
              cyc, st, rds, wrs, rdo, ms, as, ws, held, done, ldo, mis);
        checks++;
        if (ms !== 4'b1100 || ws !== 32'hABCD_0000 || as !== 32'h200) begin
            errors++; $display("FAIL sh_lanes got mbe %b wdata %h addr %h want 1100 abcd0000 200", ms, ws, as);
        end
        checks++;
        if (!done || wrs !== 3 || rds !== 0 || !held || st !== 4) begin
            errors++; $display("FAIL sh_hold got wr %0d rd %0d held %b stall %0d want 3 0 1 4", wrs, rds, held, st);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdo !== e) begin errors++; $display("FAIL sh_rdata_kept got %h want %h", rdo, e); end
        do_op(0, 1, 3'b000, 32'h201, 32'h0000_00EE, 32'h0, 1,
              cyc, st, rds, wrs, rdo, ms, as, ws, held, done, ldo, mis);
        checks++;
        if (ms !== 4'b0010 || ws !== 32'h0000_EE00 || wrs !== 1) begin
            errors++; $display("FAIL sb_lanes got mbe %b wdata %h wr %0d want 0010 0000ee00 1", ms, ws, wrs);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] e;
        exp_q.push_back(32'h0);
        mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h101;
        #1;
        checks++;
        if ({misaligned_o, stall_o, dmem_read_o, mem_wb_load_o} !== 4'b1001) begin
            errors++; $display("FAIL lw_misaligned got mis/stall/rd/ld %b want 1001",
                {misaligned_o, stall_o, dmem_read_o, mem_wb_load_o});
        end
        @(posedge clk); #2;
        mem_read_i = 0;
        #1;
        checks++;
        e = exp_q.pop_front();
        if (rdata_o !== e || misaligned_o !== 1'b0 || dmem_read_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL lw_misaligned_after got rdata %h mis %b rd %b want %h 0 0", rdata_o, misaligned_o, dmem_read_o, e);
        end
        @(posedge clk); #2;
        mem_write_i = 1; funct3_i = 3'b001; addr_i = 32'h203; wdata_i = 32'h1234;
        #1;
        checks++;
        if (misaligned_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL sh_misaligned got mis %b stall %b want 1 0", misaligned_o, stall_o);
        end
        @(posedge clk); #2;
        mem_write_i = 0;
        #1;
        checks++;
        if (dmem_write_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL sh_misaligned_nowrite got wr %b stall %b want 0 0", dmem_write_o, stall_o);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2, st, rds1, wrs1, rds2, wrs2;
        logic [31:0] rdo, as, ws, e;
        logic [3:0] ms;
        logic held, done1, done2, ldo, mis;
        exp_q.push_back(32'h0);
        do_op(0, 1, 3'b010, 32'h300, 32'h1122_3344, 32'h0, 1,
              cyc1, st, rds1, wrs1, rdo, ms, as, ws, held, done1, ldo, mis);
        checks++;
        e = exp_q.pop_front();
        if (ms !== 4'b1111 || ws !== 32'h1122_3344 || rdo !== e) begin
            errors++; $display("FAIL sw_lanes got mbe %b wdata %h rdata %h want 1111 11223344 %h", ms, ws, rdo, e);
        end
        exp_q.push_back(32'hCAFE_F00D);
        do_op(1, 0, 3'b010, 32'h304, 32'h0, 32'hCAFE_F00D, 1,
              cyc2, st, rds2, wrs2, rdo, ms, as, ws, held, done2, ldo, mis);
        checks++;
        e = exp_q.pop_front();
        if (rdo !== e || as !== 32'h304) begin
            errors++; $display("FAIL b2b_lw got rdata %h addr %h want %h 304", rdo, as, e);
        end
        checks++;
        if (!done1 || !done2 || cyc1 + cyc2 !== 6 || rds1 + rds2 !== 1 || wrs1 + wrs2 !== 1) begin
            errors++; $display("FAIL b2b_count got cycles %0d reads %0d writes %0d want 6 1 1",
                cyc1 + cyc2, rds1 + rds2, wrs1 + wrs2);
        end
        #1;
        checks++;
        if (stall_o !== 1'b0 || dmem_read_o !== 1'b0) begin
            errors++; $display("FAIL b2b_no_reissue got stall %b rd %b want 0 0", stall_o, dmem_read_o);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_reset_access();
        mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h100;
        @(posedge clk); #2; #1;
        checks++;
        if (dmem_read_o !== 1'b1) begin errors++; $display("FAIL rst_access_enter got rd %b want 1", dmem_read_o); end
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1; mem_read_i = 0;
        #1;
        checks++;
        if (dmem_read_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL rst_access_drop got rd %b stall %b want 0 0", dmem_read_o, stall_o);
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        dmem_resp_i = 1; dmem_rdata_i = 32'h1234_5678;
        @(posedge clk); #2;
        dmem_resp_i = 0;
        #1;
        checks++;
        if (rdata_o !== 32'h0 || dmem_read_o !== 1'b0 || stall_o !== 1'b0 || mem_wb_load_o !== 1'b1) begin
            errors++; $display("FAIL rst_access_late_resp got rdata %h rd %b stall %b want 0 0 0", rdata_o, dmem_read_o, stall_o);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_reset_access();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
